// File: rtl/sound_pkg.sv
// Shared types and constants for the sound scheduler: note enum, tone half periods,
// sound-code ids and the scheduler FSM state enum.
// Pure declarations; no timing or flow control here.
package sound_pkg;

  // Notes a program step can request; REST is a silent step.
  typedef enum logic [2:0] {
    NOTE_REST = 3'd0,
    NOTE_C5   = 3'd1,
    NOTE_E5   = 3'd2,
    NOTE_G5   = 3'd3,
    NOTE_C6   = 3'd4
  } note_e;

  // Tone half periods in clk cycles (100 MHz clock).
  localparam logic [16:0] HP_C5 = 17'd95602;
  localparam logic [16:0] HP_E5 = 17'd75872;
  localparam logic [16:0] HP_G5 = 17'd63775;
  localparam logic [16:0] HP_C6 = 17'd47755;

  // Sound identifiers carried on sound_code.
  localparam logic [2:0] SND_MOVE      = 3'd0;
  localparam logic [2:0] SND_CAPTURE   = 3'd1;
  localparam logic [2:0] SND_CHECK     = 3'd2;
  localparam logic [2:0] SND_PROMO     = 3'd3;
  localparam logic [2:0] SND_BLACK_WIN = 3'd4;
  localparam logic [2:0] SND_WHITE_WIN = 3'd5;
  localparam logic [2:0] SND_DRAW      = 3'd6;
  localparam logic [2:0] SND_RESERVED  = 3'd7;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Maps a note to the half period driven to the tone generator; REST is 0.
  function automatic logic [16:0] note_half_period(input note_e n);
    logic [16:0] hp;
    hp = 17'd0;
    case (n)
      NOTE_C5: hp = HP_C5;
      NOTE_E5: hp = HP_E5;
      NOTE_G5: hp = HP_G5;
      NOTE_C6: hp = HP_C6;
      default: hp = 17'd0;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/sound_rom.sv
// Program table: (sound code, step) -> note and last-step flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; read every cycle by the scheduler.
module sound_rom
  import sound_pkg::*;
(
  input  logic [2:0] i_code,
  input  logic [1:0] i_step,
  output note_e      o_note,
  output logic       o_last
);

  // Table lookup; the reserved code has no steps and reads as a single silent last step.
  always_comb begin
    o_note = NOTE_REST;
    o_last = 1'b1;
    case (i_code)
      SND_MOVE: begin
        o_note = NOTE_C5;
        o_last = 1'b1;
      end
      SND_CAPTURE: begin
        o_last = (i_step == 2'd1);
        case (i_step)
          2'd0:    o_note = NOTE_E5;
          default: o_note = NOTE_C5;
        endcase
      end
      SND_CHECK: begin
        o_last = (i_step == 2'd2);
        case (i_step)
          2'd0:    o_note = NOTE_G5;
          2'd1:    o_note = NOTE_REST;
          default: o_note = NOTE_G5;
        endcase
      end
      SND_PROMO: begin
        o_last = (i_step == 2'd3);
        case (i_step)
          2'd0:    o_note = NOTE_C5;
          2'd1:    o_note = NOTE_E5;
          2'd2:    o_note = NOTE_G5;
          default: o_note = NOTE_C6;
        endcase
      end
      SND_BLACK_WIN: begin
        o_last = (i_step == 2'd3);
        case (i_step)
          2'd0:    o_note = NOTE_C6;
          2'd1:    o_note = NOTE_G5;
          2'd2:    o_note = NOTE_E5;
          default: o_note = NOTE_C5;
        endcase
      end
      SND_WHITE_WIN: begin
        o_last = (i_step == 2'd2);
        case (i_step)
          2'd0:    o_note = NOTE_C5;
          2'd1:    o_note = NOTE_G5;
          default: o_note = NOTE_C6;
        endcase
      end
      SND_DRAW: begin
        o_last = (i_step == 2'd1);
        o_note = NOTE_E5;
      end
      default: begin
        o_note = NOTE_REST;
        o_last = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sound_scheduler.sv
// Queues sound requests and sequences each program's notes onto the tone generator outputs.
// Latency: tone valid 3 edges after the edge that raises play_sound (push, pop->LOAD, LOAD->PLAY).
// Backpressure: none upstream; requests arriving with the FIFO full (and no pop) or code 7 pulse drop.
// Optional: SOUND_PREEMPT_EN makes codes 4-6 flush the queue and abort the current sound.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int NOTE_CYC = 10000000,
  parameter int GAP_CYC  = 2000000,
  parameter int QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_sound,
  input  logic [2:0]  sound_code,
  output logic [16:0] tone_half_period,
  output logic        tone_en,
  output logic        busy,
  output logic [2:0]  q_count,
  output logic        drop
);

  localparam int AW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW   = $clog2(QDEPTH + 1);
  localparam int MAXC = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int DW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [DW-1:0] NOTE_LAST = DW'(NOTE_CYC - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_CYC - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(QDEPTH);

  state_e         r_state;
  state_e         w_next_state;

  logic [2:0]     r_mem [QDEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;

  logic [2:0]     r_code;
  logic [1:0]     r_step;
  logic [DW-1:0]  r_cnt;
  logic [16:0]    r_half;
  logic           r_en;
  logic           r_drop;

  logic           w_req;
  logic           w_flush_code;
  logic           w_flush;
  logic           w_pop;
  logic           w_push;
  logic           w_reject;
  logic [2:0]     w_head;
  note_e          w_note;
  logic           w_last;
  logic           w_note_done;
  logic           w_gap_done;

  sound_rom u_rom (
    .i_code (r_code),
    .i_step (r_step),
    .o_note (w_note),
    .o_last (w_last)
  );

`ifdef SOUND_PREEMPT_EN
  // End-of-game sounds take over immediately instead of waiting their turn.
  assign w_flush_code = (sound_code == SND_BLACK_WIN) || (sound_code == SND_WHITE_WIN) ||
                        (sound_code == SND_DRAW);
`else
  assign w_flush_code = 1'b0;
`endif

  assign w_req       = play_sound && !rst;
  assign w_flush     = w_req && w_flush_code;
  assign w_head      = r_mem[r_rptr];
  assign w_pop       = (r_state == ST_IDLE) && (r_count != '0) && !w_flush;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign w_push      = w_req && !w_flush && (sound_code != SND_RESERVED) &&
                       ((r_count < DEPTH_C) || w_pop);
  assign w_reject    = w_req && !w_push && !w_flush;
  assign w_note_done = (r_cnt == NOTE_LAST);
  assign w_gap_done  = (r_cnt == GAP_LAST);

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_mem[0] <= sound_code;
    end else if (w_push) begin
      r_mem[r_wptr] <= sound_code;
    end
  end

  // FIFO pointers and occupancy; a flush leaves the new request as the only entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= AW'(1);
      r_rptr  <= '0;
      r_count <= CW'(1);
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state logic; a flush returns to IDLE so the new head is popped next cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_pop) w_next_state = ST_LOAD;
      ST_LOAD: w_next_state = ST_PLAY;
      ST_PLAY: if (w_note_done) w_next_state = w_last ? ST_GAP : ST_LOAD;
      ST_GAP:  if (w_gap_done) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (w_flush) w_next_state = ST_IDLE;
  end

  // Sequencer datapath: current code/step, duration counter and registered tone outputs.
  // Tone is cleared on leaving PLAY, so consecutive notes (even repeats) get a one-cycle break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code <= '0;
      r_step <= '0;
      r_cnt  <= '0;
      r_half <= '0;
      r_en   <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_reject;
      if (w_flush) begin
        r_step <= '0;
        r_cnt  <= '0;
        r_half <= '0;
        r_en   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_pop) begin
              r_code <= w_head;
              r_step <= '0;
              r_cnt  <= '0;
            end
          end
          ST_LOAD: begin
            r_half <= note_half_period(w_note);
            r_en   <= (w_note != NOTE_REST);
            r_cnt  <= '0;
          end
          ST_PLAY: begin
            if (w_note_done) begin
              r_cnt  <= '0;
              r_half <= '0;
              r_en   <= 1'b0;
              r_step <= w_last ? 2'd0 : (r_step + 2'd1);
            end else begin
              r_cnt <= r_cnt + DW'(1);
            end
          end
          ST_GAP: begin
            r_cnt <= w_gap_done ? '0 : (r_cnt + DW'(1));
          end
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  assign tone_half_period = r_half;
  assign tone_en          = r_en;
  assign busy             = (r_state != ST_IDLE) || (r_count != '0);
  assign q_count          = 3'(r_count);
  assign drop             = r_drop;

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler with a note-order scoreboard.
// Timing: inputs driven and outputs sampled 1 time unit after the rising edge.
// Backpressure: full-queue drops, push-with-pop and code 7 rejection are exercised.
module tb_sound_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play_sound = 1'b0;
  logic [2:0]  sound_code = 3'd0;
  logic [16:0] tone_half_period;
  logic        tone_en;
  logic        busy;
  logic [2:0]  q_count;
  logic        drop;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int exp_q[$];
  logic prev_on = 1'b0;

  localparam int C5 = 95602;
  localparam int E5 = 75872;
  localparam int G5 = 63775;
  localparam int C6 = 47755;

  sound_scheduler #(
    .NOTE_CYC (20),
    .GAP_CYC  (5),
    .QDEPTH   (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .play_sound       (play_sound),
    .sound_code       (sound_code),
    .tone_half_period (tone_half_period),
    .tone_en          (tone_en),
    .busy             (busy),
    .q_count          (q_count),
    .drop             (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Audible notes each program should produce, in order (REST steps are silent).
  task automatic push_notes(input logic [2:0] c);
    case (c)
      3'd0: exp_q.push_back(C5);
      3'd1: begin exp_q.push_back(E5); exp_q.push_back(C5); end
      3'd2: begin exp_q.push_back(G5); exp_q.push_back(G5); end
      3'd3: begin exp_q.push_back(C5); exp_q.push_back(E5); exp_q.push_back(G5); exp_q.push_back(C6); end
      3'd4: begin exp_q.push_back(C6); exp_q.push_back(G5); exp_q.push_back(E5); exp_q.push_back(C5); end
      3'd5: begin exp_q.push_back(C5); exp_q.push_back(G5); exp_q.push_back(C6); end
      3'd6: begin exp_q.push_back(E5); exp_q.push_back(E5); end
      default: ;
    endcase
  endtask

  task automatic strobe(input logic [2:0] c, input bit accept);
    play_sound = 1'b1;
    sound_code = c;
    if (accept) push_notes(c);
    tick();
    play_sound = 1'b0;
  endtask

  task automatic run_len(input logic [16:0] v, output int len);
    len = 0;
    while (({tone_en, tone_half_period} === {(v != 17'd0), v}) && (len < 200)) begin
      len++;
      tick();
    end
  endtask

  task automatic gap_len(output int len);
    len = 0;
    while ((busy === 1'b1) && (tone_en === 1'b0) && (len < 50)) begin
      len++;
      tick();
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0) && (n < budget)) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  // Scoreboard: every start of an audible note is compared with the next expected note.
  always @(negedge clk) begin
    if (!rst && tone_en === 1'b1 && !prev_on) begin
      if (exp_q.size() == 0) check("unexpected_note", tone_half_period, 0);
      else                   check("note_order", tone_half_period, exp_q.pop_front());
    end
    prev_on = (tone_en === 1'b1);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int drops;
    int n;

    // Reset state
    tick();
    tick();
    check("rst_hp", tone_half_period, 0);
    check("rst_en", tone_en, 0);
    check("rst_busy", busy, 0);
    check("rst_qcount", q_count, 0);
    check("rst_drop", drop, 0);
    rst = 1'b0;
    tick();

    // Single move sound: latency, note length, gap length
    strobe(3'd0, 1'b1);
    check("move_qcount", q_count, 1);
    check("move_busy", busy, 1);
    tick();
    check("move_load_silent", tone_en, 0);
    tick();
    check("move_edge3_hp", tone_half_period, C5);
    check("move_edge3_en", tone_en, 1);
    run_len(17'(C5), len);
    check("move_note_len", len, 20);
    gap_len(len);
    check("move_gap_len", len, 5);
    check("move_idle", busy, 0);

    // Check sound with a REST step in the middle
    strobe(3'd2, 1'b1);
    tick();
    tick();
    run_len(17'(G5), len);
    check("check_note1_len", len, 20);
    run_len(17'd0, len);
    check("check_rest_len", len, 22);
    run_len(17'(G5), len);
    check("check_note3_len", len, 20);
    gap_len(len);
    check("check_gap_len", len, 5);
    check("check_idle", busy, 0);

    // Queue saturation: six capture requests while a move plays
    strobe(3'd0, 1'b1);
    tick();
    tick();
    tick();
    drops = 0;
    for (int i = 0; i < 6; i++) begin
      strobe(3'd1, i < 4);
      drops += int'(drop);
      check("fill_qcount", q_count, (i < 4) ? i + 1 : 4);
    end
    check("fill_drops", drops, 2);
    tick();
    check("fill_drop_one_cycle", drop, 0);
    n = 0;
    while ((tone_en === 1'b1) && (n < 100)) begin
      tick();
      n++;
    end
    check("fill_note_end", tone_en, 0);
    for (int i = 0; i < 5; i++) tick();
    // FSM is now IDLE with a full queue: this request meets a pop and is accepted.
    strobe(3'd1, 1'b1);
    check("push_with_pop_qcount", q_count, 4);
    check("push_with_pop_drop", drop, 0);
    wait_idle(2000);
    check("fill_sb_empty", exp_q.size(), 0);

    // Reserved code is rejected
    strobe(3'd7, 1'b0);
    check("code7_drop", drop, 1);
    check("code7_qcount", q_count, 0);
    check("code7_busy", busy, 0);
    tick();
    check("code7_drop_clear", drop, 0);
    check("code7_tone", tone_en, 0);

    // Reset in the middle of a promotion sound
    strobe(3'd3, 1'b1);
    tick();
    tick();
    check("promo_first_hp", tone_half_period, C5);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_hp", tone_half_period, 0);
    check("midrst_en", tone_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_qcount", q_count, 0);
    check("midrst_drop", drop, 0);
    play_sound = 1'b1;
    sound_code = 3'd0;
    tick();
    tick();
    play_sound = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_qcount", q_count, 0);
    check("post_rst_busy", busy, 0);
    strobe(3'd0, 1'b1);
    tick();
    tick();
    check("post_rst_hp", tone_half_period, C5);
    check("post_rst_en", tone_en, 1);
    wait_idle(200);

    // Black-win request while a promotion plays with two captures queued
    strobe(3'd3, 1'b1);
    tick();
    tick();
    strobe(3'd1, 1'b1);
    strobe(3'd1, 1'b1);
    check("pre_win_qcount", q_count, 2);
`ifdef SOUND_PREEMPT_EN
    exp_q.delete();
    strobe(3'd4, 1'b1);
    check("preempt_tone_off", tone_en, 0);
    check("preempt_qcount", q_count, 1);
    check("preempt_drop", drop, 0);
    tick();
    tick();
    check("preempt_hp", tone_half_period, C6);
    check("preempt_en", tone_en, 1);
`else
    strobe(3'd4, 1'b1);
    check("queued_win_qcount", q_count, 3);
    check("queued_win_tone", tone_en, 1);
    check("queued_win_hp", tone_half_period, C5);
    check("queued_win_drop", drop, 0);
`endif
    wait_idle(2000);
    check("final_sb_empty", exp_q.size(), 0);
    check("final_qcount", q_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
